// File: rtl/ln_mult_scheduler.sv
// Shares one unsigned 32x32 multiplier between the normalization port (x NORM_K)
// and the generic port. Each operation is sequenced IDLE -> EXEC -> RESP.
module ln_mult_scheduler #(
    parameter logic [31:0] NORM_K = 32'h0038_9374,
    parameter bit          RR     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        norm_req,
    input  logic [31:0] norm_a,
    output logic        norm_gnt,
    output logic        norm_done,
    output logic [31:0] norm_y,
    output logic        norm_ovf,
    input  logic        mul_req,
    input  logic [31:0] mul_a,
    input  logic [31:0] mul_b,
    output logic        mul_gnt,
    output logic        mul_done,
    output logic [63:0] mul_y,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic {OWN_NORM = 1'b0, OWN_MUL = 1'b1} owner_t;

    state_t      state, state_nxt;
    owner_t      owner, last_owner;
    logic [31:0] op_a, op_b;
    logic        sel_norm, sel_mul;
    logic [63:0] prod;
    logic        prod_ovf;
    logic [31:0] prod_norm;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        sel_norm  = 1'b0;
        sel_mul   = 1'b0;
        case (state)
            IDLE: begin
                if (norm_req && mul_req) begin
                    if (RR && last_owner == OWN_NORM) sel_mul  = 1'b1;
                    else                              sel_norm = 1'b1;
                end else begin
                    sel_norm = norm_req;
                    sel_mul  = mul_req;
                end
                if (sel_norm || sel_mul) state_nxt = EXEC;
            end
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A grant is only meaningful when the edge will actually accept it.
    assign norm_gnt = sel_norm & rst;
    assign mul_gnt  = sel_mul & rst;
    assign busy     = (state != IDLE);

    assign prod      = 64'(op_a) * 64'(op_b);
    assign prod_ovf  = |prod[63:54];
    assign prod_norm = prod_ovf ? 32'hFFFF_FFFF : prod[53:22];

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_NORM;
            last_owner <= OWN_MUL;
            op_a       <= '0;
            op_b       <= '0;
            norm_done  <= 1'b0;
            norm_y     <= '0;
            norm_ovf   <= 1'b0;
            mul_done   <= 1'b0;
            mul_y      <= '0;
        end else begin
            state     <= state_nxt;
            norm_done <= 1'b0;
            mul_done  <= 1'b0;
            if (state == IDLE && (sel_norm || sel_mul)) begin
                op_a       <= sel_norm ? norm_a : mul_a;
                op_b       <= sel_norm ? NORM_K : mul_b;
                owner      <= sel_norm ? OWN_NORM : OWN_MUL;
                last_owner <= sel_norm ? OWN_NORM : OWN_MUL;
            end
            if (state == EXEC) begin
                if (owner == OWN_NORM) begin
                    norm_y    <= prod_norm;
                    norm_ovf  <= prod_ovf;
                    norm_done <= 1'b1;
                end else begin
                    mul_y    <= prod;
                    mul_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ln_mult_scheduler.sv
// Bench for ln_mult_scheduler: three instances (default, fixed-priority, large K) share
// stimulus and are compared every cycle against a transaction-level model.
module tb_ln_mult_scheduler;

    localparam logic [31:0] KV  [3] = '{32'h0038_9374, 32'h0038_9374, 32'h0100_0000};
    localparam bit          RRV [3] = '{1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        norm_req = 1'b0, mul_req = 1'b0;
    logic [31:0] norm_a = '0, mul_a = '0, mul_b = '0;

    logic        ngnt [3], nd [3], novf [3], mgnt [3], md [3], bsy [3];
    logic [31:0] ny [3];
    logic [63:0] my [3];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ln_mult_scheduler #(.NORM_K(KV[g]), .RR(RRV[g])) dut (
            .clk(clk), .rst(rst),
            .norm_req(norm_req), .norm_a(norm_a), .norm_gnt(ngnt[g]),
            .norm_done(nd[g]), .norm_y(ny[g]), .norm_ovf(novf[g]),
            .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_gnt(mgnt[g]),
            .mul_done(md[g]), .mul_y(my[g]), .busy(bsy[g])
        );
    end

    // Model: an accepted request occupies the multiplier for two more cycles; the result
    // is computed at acceptance and published (with done) in the second of those cycles.
    int          rem [3];
    bit          own_norm [3];
    bit          last_mul [3];
    logic [63:0] pend [3];
    logic [31:0] e_ny [3];
    logic [63:0] e_my [3];
    bit          e_novf [3], e_nd [3], e_md [3];

    function automatic logic [1:0] pick(int i);
        if (!rst || rem[i] != 0)    return 2'b00;
        if (norm_req && mul_req)    return (!RRV[i] || last_mul[i]) ? 2'b10 : 2'b01;
        return {norm_req, mul_req};
    endfunction

    function automatic bit sat(logic [63:0] p);
        return p >= (64'd1 << 54);
    endfunction

    function automatic logic [31:0] norm_res(logic [63:0] p);
        return sat(p) ? 32'hFFFF_FFFF : 32'(p >> 22);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                rem[i] <= 0; own_norm[i] <= 1'b0; last_mul[i] <= 1'b1; pend[i] <= '0;
                e_ny[i] <= '0; e_novf[i] <= 1'b0; e_my[i] <= '0;
                e_nd[i] <= 1'b0; e_md[i] <= 1'b0;
            end else begin
                e_nd[i] <= 1'b0;
                e_md[i] <= 1'b0;
                if (rem[i] == 2) begin
                    rem[i] <= 1;
                    if (own_norm[i]) begin
                        e_ny[i] <= norm_res(pend[i]); e_novf[i] <= sat(pend[i]); e_nd[i] <= 1'b1;
                    end else begin
                        e_my[i] <= pend[i]; e_md[i] <= 1'b1;
                    end
                end else if (rem[i] == 1) begin
                    rem[i] <= 0;
                end else if (pick(i) != 2'b00) begin
                    rem[i]      <= 2;
                    own_norm[i] <= (pick(i) == 2'b10);
                    last_mul[i] <= (pick(i) == 2'b01);
                    pend[i]     <= (pick(i) == 2'b10) ? 64'(norm_a) * 64'(KV[i])
                                                      : 64'(mul_a) * 64'(mul_b);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("norm_gnt[%0d]", i), 64'(ngnt[i]), 64'(pick(i) == 2'b10));
                check($sformatf("mul_gnt[%0d]", i),  64'(mgnt[i]), 64'(pick(i) == 2'b01));
                check($sformatf("busy[%0d]", i),     64'(bsy[i]),  64'(rem[i] != 0));
                check($sformatf("norm_done[%0d]", i), 64'(nd[i]),  64'(e_nd[i]));
                check($sformatf("mul_done[%0d]", i), 64'(md[i]),   64'(e_md[i]));
                check($sformatf("norm_y[%0d]", i),   64'(ny[i]),   64'(e_ny[i]));
                check($sformatf("norm_ovf[%0d]", i), 64'(novf[i]), 64'(e_novf[i]));
                check($sformatf("mul_y[%0d]", i),    my[i],        e_my[i]);
            end
        end
    end

    // Issues one request on every instance and checks that done follows the grant by 2 cycles.
    task automatic do_op(input bit is_norm, input logic [31:0] a, input logic [31:0] b, input int inst);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (is_norm) begin norm_req = 1'b1; norm_a = a; end
        else begin mul_req = 1'b1; mul_a = a; mul_b = b; end
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = is_norm ? ngnt[inst] : mgnt[inst];
        end
        check("gnt_within_budget", 64'(got), 64'd1);
        @(posedge clk); #1;
        norm_req = 1'b0; mul_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("done_two_after_gnt", 64'(is_norm ? nd[inst] : md[inst]), 64'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", 64'(bsy[0]), 64'd0);
        check("reset_norm_y", 64'(ny[0]), 64'd0);
        check("reset_mul_y", my[0], 64'd0);
        check("reset_gnt", 64'(ngnt[0]), 64'd0);
        @(posedge clk); #1 rst = 1'b1;

        do_op(1'b1, 32'h2000_0000, 32'h0, 0);
        check("norm_y_basic", 64'(ny[0]), 64'h1C49_BA00);
        check("norm_ovf_basic", 64'(novf[0]), 64'd0);
        check("mul_y_untouched", my[0], 64'd0);

        do_op(1'b1, 32'hFFFF_FFFF, 32'h0, 0);
        check("norm_y_max", 64'(ny[0]), 64'hE24D_CFFF);
        check("norm_ovf_max", 64'(novf[0]), 64'd0);
        check("bigk_ovf_max", 64'(novf[2]), 64'd1);
        check("bigk_y_max", 64'(ny[2]), 64'hFFFF_FFFF);

        do_op(1'b1, 32'h8000_0000, 32'h0, 2);
        check("bigk_ovf", 64'(novf[2]), 64'd1);
        check("bigk_y_sat", 64'(ny[2]), 64'hFFFF_FFFF);
        check("norm_y_half", 64'(ny[0]), 64'h7126_E800);

        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mul_y_max", my[0], 64'hFFFF_FFFE_0000_0001);
        check("norm_y_held", 64'(ny[0]), 64'h7126_E800);

        // Both requesters held for 12 cycles.
        @(posedge clk); #1;
        norm_req = 1'b1; mul_req = 1'b1;
        norm_a = $urandom; mul_a = $urandom; mul_b = $urandom;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("rr_norm_gnt", 64'(ngnt[0]), 64'((c % 3 == 0) && ((c / 3) % 2 == 0)));
            check("rr_mul_gnt",  64'(mgnt[0]), 64'((c % 3 == 0) && ((c / 3) % 2 == 1)));
            check("rr_done_lat", 64'(nd[0] | md[0]), 64'(c % 3 == 2));
            check("fp_norm_gnt", 64'(ngnt[1]), 64'(c % 3 == 0));
            check("fp_mul_gnt",  64'(mgnt[1]), 64'd0);
            check("fp_norm_done", 64'(nd[1]), 64'(c % 3 == 2));
        end
        @(posedge clk); #1;
        norm_req = 1'b0; mul_req = 1'b0;

        // Reset asserted while the operation is in EXEC.
        do_op(1'b1, 32'h8000_0000, 32'h0, 0);
        @(posedge clk); #1;
        norm_req = 1'b1; norm_a = 32'h2000_0000;
        @(negedge clk);
        check("rst_case_gnt", 64'(ngnt[0]), 64'd1);
        @(posedge clk); #1;
        norm_req = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("rst_case_exec_busy", 64'(bsy[0]), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_case_done", 64'(nd[0]), 64'd0);
        check("rst_case_busy", 64'(bsy[0]), 64'd0);
        check("rst_case_norm_y", 64'(ny[0]), 64'd0);
        check("rst_case_mul_y", my[0], 64'd0);
        @(negedge clk);
        check("rst_case_no_late_done", 64'(nd[0]), 64'd0);
        do_op(1'b1, 32'h2000_0000, 32'h0, 0);
        check("post_rst_norm_y", 64'(ny[0]), 64'h1C49_BA00);

        // Randomized traffic, including occasional resets and extreme operands.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst      = ($urandom_range(0, 99) != 0);
            norm_req = ($urandom_range(0, 2) != 0);
            mul_req  = ($urandom_range(0, 2) != 0);
            norm_a   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            mul_a    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            mul_b    = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        end
        @(posedge clk); #1;
        rst = 1'b1; norm_req = 1'b0; mul_req = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
